// File: rtl/sm_controller_if.sv
// Start handshake and datapath-control bundle between the sequencer and its datapath.
// The retired-instruction count is only present when SMC_RETIRE_CNT_EN is defined.
interface sm_controller_if #(
    parameter int DATA_W = 16
);
    logic              s;
    logic [15:0]       instr;
    logic              w;
    logic [2:0]        readnum;
    logic [2:0]        writenum;
    logic              write;
    logic              loada;
    logic              loadb;
    logic              loadc;
    logic              loads;
    logic              asel;
    logic              bsel;
    logic [1:0]        vsel;
    logic [1:0]        shift;
    logic [1:0]        aluop;
    logic [DATA_W-1:0] sximm8;
    logic              illegal;
`ifdef SMC_RETIRE_CNT_EN
    logic [15:0]       retired;
`endif

`ifdef SMC_RETIRE_CNT_EN
    modport master (
        output s, instr,
        input  w, readnum, writenum, write, loada, loadb, loadc, loads,
        input  asel, bsel, vsel, shift, aluop, sximm8, illegal, retired
    );
    modport slave (
        input  s, instr,
        output w, readnum, writenum, write, loada, loadb, loadc, loads,
        output asel, bsel, vsel, shift, aluop, sximm8, illegal, retired
    );
`else
    modport master (
        output s, instr,
        input  w, readnum, writenum, write, loada, loadb, loadc, loads,
        input  asel, bsel, vsel, shift, aluop, sximm8, illegal
    );
    modport slave (
        input  s, instr,
        output w, readnum, writenum, write, loada, loadb, loadc, loads,
        output asel, bsel, vsel, shift, aluop, sximm8, illegal
    );
`endif
endinterface

// File: rtl/sm_controller.sv
// Multi-cycle Moore sequencer for the Simple RISC datapath (regfile, A/B/C, shifter, ALU).
// Define SMC_RETIRE_CNT_EN to add the 16-bit retired-instruction counter.
//
// state     | meaning
// ----------+--------------------------------------------------------
// WAIT      | idle, w=1, IR captures instr when s=1
// DECODE    | classify IR; flags illegal and returns to WAIT if unsupported
// GET_A     | read Rn into A (two-operand ALU ops only)
// GET_B     | read Rm into B
// EXEC      | ALU result into C; CMP updates status and retires here
// WRITE_REG | write C back to Rd
// WRITE_IMM | write sign-extended immediate to Rn
module sm_controller #(
    parameter int DATA_W = 16
) (
    input  logic           clk,
    input  logic           reset_n,
    sm_controller_if.slave bus
);

    typedef enum logic [2:0] {
        S_WAIT      = 3'd0,
        S_DECODE    = 3'd1,
        S_GET_A     = 3'd2,
        S_GET_B     = 3'd3,
        S_EXEC      = 3'd4,
        S_WRITE_REG = 3'd5,
        S_WRITE_IMM = 3'd6
    } state_t;

    localparam logic [2:0] OPC_MOV = 3'b110;
    localparam logic [2:0] OPC_ALU = 3'b101;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_ir;

    logic [2:0]  w_opcode;
    logic [1:0]  w_op;
    logic [2:0]  w_rn;
    logic [2:0]  w_rd;
    logic [1:0]  w_sh;
    logic [2:0]  w_rm;

    logic        w_mov_imm;
    logic        w_mov_reg;
    logic        w_alu;
    logic        w_cmp;
    logic        w_mvn;
    logic        w_zero_a;

    logic [2:0]  w_readnum;
    logic [2:0]  w_writenum;
    logic        w_write;
    logic        w_loada;
    logic        w_loadb;
    logic        w_loadc;
    logic        w_loads;
    logic        w_asel;
    logic [1:0]  w_vsel;
    logic        w_illegal;

    assign w_opcode  = r_ir[15:13];
    assign w_op      = r_ir[12:11];
    assign w_rn      = r_ir[10:8];
    assign w_rd      = r_ir[7:5];
    assign w_sh      = r_ir[4:3];
    assign w_rm      = r_ir[2:0];

    assign w_mov_imm = (w_opcode == OPC_MOV) && (w_op == 2'b10);
    assign w_mov_reg = (w_opcode == OPC_MOV) && (w_op == 2'b00);
    assign w_alu     = (w_opcode == OPC_ALU);
    assign w_cmp     = w_alu && (w_op == 2'b01);
    assign w_mvn     = w_alu && (w_op == 2'b11);
    // MOV reg and MVN are single-operand: the ALU sees zero on its A side.
    assign w_zero_a  = w_mov_reg || w_mvn;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ir <= '0;
        end else if ((r_state == S_WAIT) && bus.s) begin
            r_ir <= bus.instr;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_WAIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_WAIT: begin
                if (bus.s) begin
                    w_state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                if (w_mov_imm) begin
                    w_state_nxt = S_WRITE_IMM;
                end else if (w_zero_a) begin
                    w_state_nxt = S_GET_B;
                end else if (w_alu) begin
                    w_state_nxt = S_GET_A;
                end else begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_GET_A:     w_state_nxt = S_GET_B;
            S_GET_B:     w_state_nxt = S_EXEC;
            S_EXEC:      w_state_nxt = w_cmp ? S_WAIT : S_WRITE_REG;
            S_WRITE_REG: w_state_nxt = S_WAIT;
            S_WRITE_IMM: w_state_nxt = S_WAIT;
            default:     w_state_nxt = S_WAIT;
        endcase
    end

    always_comb begin
        w_readnum  = 3'b000;
        w_writenum = 3'b000;
        w_write    = 1'b0;
        w_loada    = 1'b0;
        w_loadb    = 1'b0;
        w_loadc    = 1'b0;
        w_loads    = 1'b0;
        w_asel     = 1'b0;
        w_vsel     = 2'b00;
        w_illegal  = 1'b0;
        unique case (r_state)
            S_DECODE: begin
                w_illegal = !(w_mov_imm || w_mov_reg || w_alu);
            end
            S_GET_A: begin
                w_readnum = w_rn;
                w_loada   = 1'b1;
            end
            S_GET_B: begin
                w_readnum = w_rm;
                w_loadb   = 1'b1;
            end
            S_EXEC: begin
                w_loadc = 1'b1;
                w_asel  = w_zero_a;
                w_loads = w_cmp;
            end
            S_WRITE_REG: begin
                w_writenum = w_rd;
                w_vsel     = 2'b00;
                w_write    = 1'b1;
            end
            S_WRITE_IMM: begin
                w_writenum = w_rn;
                w_vsel     = 2'b01;
                w_write    = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign bus.w        = (r_state == S_WAIT);
    assign bus.readnum  = w_readnum;
    assign bus.writenum = w_writenum;
    assign bus.write    = w_write;
    assign bus.loada    = w_loada;
    assign bus.loadb    = w_loadb;
    assign bus.loadc    = w_loadc;
    assign bus.loads    = w_loads;
    assign bus.asel     = w_asel;
    assign bus.bsel     = 1'b0;
    assign bus.vsel     = w_vsel;
    assign bus.illegal  = w_illegal;
    assign bus.aluop    = w_op;
    // The immediate move must pass the shifter untouched even though IR[4:3] holds immediate bits.
    assign bus.shift    = w_mov_imm ? 2'b00 : w_sh;
    assign bus.sximm8   = DATA_W'($signed(r_ir[7:0]));

`ifdef SMC_RETIRE_CNT_EN
    logic [15:0] r_retired;
    logic        w_retire;

    assign w_retire = (r_state == S_WRITE_REG) || (r_state == S_WRITE_IMM) ||
                      ((r_state == S_EXEC) && w_cmp);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_retired <= '0;
        end else if (w_retire) begin
            r_retired <= r_retired + 16'd1;
        end
    end

    assign bus.retired = r_retired;
`endif

endmodule

// File: tb/tb_sm_controller.sv
// Directed bench for sm_controller: per-instruction timing model checked every cycle,
// plus literal expectations for latency, write pulses and field routing.
module tb_sm_controller;
    localparam int DATA_W = 16;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    sm_controller_if #(.DATA_W(DATA_W)) bus ();

    sm_controller #(.DATA_W(DATA_W)) u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad < 60) $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: cycles elapsed since the accepted start ----------------
    bit          m_busy = 1'b0;
    int          m_k = 0;
    int          m_lat = 0;
    logic [15:0] m_ir = 16'h0000;
    logic [15:0] m_ret = 16'h0000;

    function automatic bit is_movimm(input logic [15:0] ir);
        return (ir[15:13] == 3'b110) && (ir[12:11] == 2'b10);
    endfunction
    function automatic bit is_onesrc(input logic [15:0] ir);
        return ((ir[15:13] == 3'b110) && (ir[12:11] == 2'b00)) ||
               ((ir[15:13] == 3'b101) && (ir[12:11] == 2'b11));
    endfunction
    function automatic bit is_twosrc(input logic [15:0] ir);
        return (ir[15:13] == 3'b101) && (ir[12:11] != 2'b11);
    endfunction
    function automatic bit is_cmp(input logic [15:0] ir);
        return (ir[15:13] == 3'b101) && (ir[12:11] == 2'b01);
    endfunction
    function automatic bit is_ill(input logic [15:0] ir);
        return !(is_movimm(ir) || is_onesrc(ir) || is_twosrc(ir));
    endfunction
    function automatic int latency(input logic [15:0] ir);
        if (is_movimm(ir)) return 3;
        if (is_onesrc(ir)) return 5;
        if (is_cmp(ir))    return 5;
        if (is_twosrc(ir)) return 6;
        return 2;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_busy = 1'b0;
            m_k    = 0;
            m_ir   = 16'h0000;
            m_ret  = 16'h0000;
        end else if (m_busy) begin
            m_k++;
            if (m_k == m_lat) begin
                m_busy = 1'b0;
                if (!is_ill(m_ir)) m_ret = m_ret + 16'd1;
            end
        end else if (bus.s) begin
            m_busy = 1'b1;
            m_k    = 1;
            m_ir   = bus.instr;
            m_lat  = latency(bus.instr);
        end
    end

    always @(negedge clk) begin : compare
        logic [2:0]        e_rd, e_wr;
        logic              e_write, e_la, e_lb, e_lc, e_ls, e_asel, e_ill;
        logic [1:0]        e_vsel, e_sh;
        logic [DATA_W-1:0] e_sx;
        int                exec_k;
        e_rd = 0; e_wr = 0; e_write = 0; e_la = 0; e_lb = 0; e_lc = 0;
        e_ls = 0; e_asel = 0; e_ill = 0; e_vsel = 0;
        exec_k = is_twosrc(m_ir) ? 4 : 3;
        if (m_busy) begin
            e_ill = is_ill(m_ir) && (m_k == 1);
            if (is_twosrc(m_ir) && m_k == 2) begin e_rd = m_ir[10:8]; e_la = 1; end
            if (is_twosrc(m_ir) && m_k == 3) begin e_rd = m_ir[2:0];  e_lb = 1; end
            if (is_onesrc(m_ir) && m_k == 2) begin e_rd = m_ir[2:0];  e_lb = 1; end
            if ((is_twosrc(m_ir) || is_onesrc(m_ir)) && m_k == exec_k) begin
                e_lc = 1; e_asel = is_onesrc(m_ir); e_ls = is_cmp(m_ir);
            end
            if (!is_cmp(m_ir) && !is_ill(m_ir) && m_k == m_lat - 1) begin
                e_write = 1;
                e_wr    = is_movimm(m_ir) ? m_ir[10:8] : m_ir[7:5];
                e_vsel  = is_movimm(m_ir) ? 2'b01 : 2'b00;
            end
        end
        e_sh = is_movimm(m_ir) ? 2'b00 : m_ir[4:3];
        e_sx = DATA_W'(m_ir[7:0]);
        if (m_ir[7]) e_sx = e_sx + DATA_W'((1 << DATA_W) - 256);
        chk("w",        bus.w,        !m_busy);
        chk("readnum",  bus.readnum,  e_rd);
        chk("writenum", bus.writenum, e_wr);
        chk("write",    bus.write,    e_write);
        chk("loada",    bus.loada,    e_la);
        chk("loadb",    bus.loadb,    e_lb);
        chk("loadc",    bus.loadc,    e_lc);
        chk("loads",    bus.loads,    e_ls);
        chk("asel",     bus.asel,     e_asel);
        chk("bsel",     bus.bsel,     1'b0);
        chk("vsel",     bus.vsel,     e_vsel);
        chk("shift",    bus.shift,    e_sh);
        chk("aluop",    bus.aluop,    m_ir[12:11]);
        chk("sximm8",   bus.sximm8,   e_sx);
        chk("illegal",  bus.illegal,  e_ill);
`ifdef SMC_RETIRE_CNT_EN
        chk("retired",  bus.retired,  m_ret);
`endif
    end

    // ---------------- stimulus ----------------
    typedef struct {
        int                lat, nwr, nill, wcyc, nloads;
        logic [2:0]        wnum, ra, rb;
        logic [1:0]        wvsel, ealu, esh;
        logic              easel;
        logic [DATA_W-1:0] wsx;
    } obs_t;

    task automatic run(input logic [15:0] ins, output obs_t o);
        o.lat = 1; o.nwr = 0; o.nill = 0; o.wcyc = 0; o.nloads = 0;
        o.wnum = 'x; o.ra = 'x; o.rb = 'x; o.wvsel = 'x; o.ealu = 'x; o.esh = 'x;
        o.easel = 'x; o.wsx = 'x;
        @(posedge clk); #1; bus.s = 1'b1; bus.instr = ins;
        @(posedge clk); #1; bus.s = 1'b0; bus.instr = 16'($urandom);
        while (o.lat <= 20 && !bus.w) begin
            if (bus.write) begin
                o.nwr++; o.wnum = bus.writenum; o.wvsel = bus.vsel; o.wcyc = o.lat; o.wsx = bus.sximm8;
            end
            if (bus.illegal) o.nill++;
            if (bus.loada) o.ra = bus.readnum;
            if (bus.loadb) o.rb = bus.readnum;
            if (bus.loads) o.nloads++;
            if (bus.loadc) begin o.easel = bus.asel; o.ealu = bus.aluop; o.esh = bus.shift; end
            @(posedge clk); #1; o.lat++;
        end
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        obs_t o;
        int   nwr, nw, lim;
        logic [15:0] r0;
        bus.s = 1'b0;
        bus.instr = 16'h0000;
        #12;
        chk("rst_w", bus.w, 1'b1);
        chk("rst_write", bus.write, 1'b0);
        chk("rst_sximm8", bus.sximm8, '0);
        #11 reset_n = 1'b1;
        r0 = 0;

        run(16'hD007, o);  // MOV R0,#7
        chk("movi_lat", o.lat, 3); chk("movi_nwr", o.nwr, 1); chk("movi_wcyc", o.wcyc, 2);
        chk("movi_wnum", o.wnum, 3'd0); chk("movi_vsel", o.wvsel, 2'b01); chk("movi_sx", o.wsx, 16'h0007);

        run(16'hD1FE, o);  // MOV R1,#-2
        chk("movn_lat", o.lat, 3); chk("movn_wnum", o.wnum, 3'd1); chk("movn_sx", o.wsx, 16'hFFFE);

`ifdef SMC_RETIRE_CNT_EN
        r0 = bus.retired;
`endif
        run(16'hA140, o);  // ADD R2,R1,R0
        chk("add_lat", o.lat, 6); chk("add_ra", o.ra, 3'd1); chk("add_rb", o.rb, 3'd0);
        chk("add_asel", o.easel, 1'b0); chk("add_alu", o.ealu, 2'b00); chk("add_wnum", o.wnum, 3'd2);
        chk("add_wcyc", o.wcyc, 5); chk("add_nwr", o.nwr, 1); chk("add_loads", o.nloads, 0);
`ifdef SMC_RETIRE_CNT_EN
        chk("add_retired", bus.retired, r0 + 16'd1);
`endif

        run(16'hA801, o);  // CMP R0,R1
        chk("cmp_lat", o.lat, 5); chk("cmp_nwr", o.nwr, 0); chk("cmp_loads", o.nloads, 1);
        chk("cmp_alu", o.ealu, 2'b01); chk("cmp_ra", o.ra, 3'd0); chk("cmp_rb", o.rb, 3'd1);

`ifdef SMC_RETIRE_CNT_EN
        r0 = bus.retired;
`endif
        run(16'h0000, o);  // unsupported opcode
        chk("ill_lat", o.lat, 2); chk("ill_pulse", o.nill, 1); chk("ill_nwr", o.nwr, 0);
`ifdef SMC_RETIRE_CNT_EN
        chk("ill_retired", bus.retired, r0);
`endif

        run(16'hC06D, o);  // MOV R3,R5 LSL
        chk("movr_lat", o.lat, 5); chk("movr_rb", o.rb, 3'd5); chk("movr_asel", o.easel, 1'b1);
        chk("movr_sh", o.esh, 2'b01); chk("movr_wnum", o.wnum, 3'd3);

        run(16'hB8E2, o);  // MVN R7,R2
        chk("mvn_lat", o.lat, 5); chk("mvn_asel", o.easel, 1'b1); chk("mvn_wnum", o.wnum, 3'd7);
        chk("mvn_alu", o.ealu, 2'b11);

        run(16'hB386, o);  // AND R4,R3,R6
        chk("and_lat", o.lat, 6); chk("and_ra", o.ra, 3'd3); chk("and_rb", o.rb, 3'd6);
        chk("and_wnum", o.wnum, 3'd4);

        run(16'hD800, o);  // 110/11 unsupported
        chk("ill2_lat", o.lat, 2); chk("ill2_pulse", o.nill, 1);

        // s held high: one idle cycle between back-to-back MOV imm instructions
        @(posedge clk); #1; bus.s = 1'b1; bus.instr = 16'hD007;
        nwr = 0; nw = 0;
        repeat (8) begin
            @(posedge clk); #1; nwr += int'(bus.write); nw += int'(bus.w);
        end
        bus.s = 1'b0;
        chk("b2b_writes", nwr, 3); chk("b2b_wcycles", nw, 2);
        lim = 0;
        while (!bus.w && lim < 20) begin @(posedge clk); #1; lim++; end
        chk("b2b_drain", lim < 20, 1'b1);

        // reset asserted while ADD sits in EXEC
        @(posedge clk); #1; bus.s = 1'b1; bus.instr = 16'hA140;
        @(posedge clk); #1; bus.s = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk("abort_exec", bus.loadc, 1'b1);
        #1 reset_n = 1'b0;
        #1 chk("abort_w", bus.w, 1'b1); chk("abort_write", bus.write, 1'b0);
        chk("abort_loadc", bus.loadc, 1'b0);
        @(posedge clk); #3 reset_n = 1'b1;
        nwr = 0;
        repeat (8) begin @(posedge clk); #1; nwr += int'(bus.write); end
        chk("abort_nowrite", nwr, 0);

        run(16'hD1FE, o);
        chk("post_lat", o.lat, 3); chk("post_wnum", o.wnum, 3'd1);

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sm_controller.md
Name: sm_controller

Overview:
- Multi-cycle Moore FSM that sequences the 8x16 register file, the A/B/C operand registers, the shifter and the ALU of the Simple RISC datapath.
- Latches a 16-bit instruction on a start handshake, decodes it, and drives read/write register numbers, load enables and mux selects state by state.
- Returns to idle when the instruction retires.

Parameters:
- DATA_W, 16, width of sign-extended immediate output sximm8 (must be >= 8)

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- s  in  1  start request; sampled only while w=1
- instr  in  16  instruction word; captured on the accepted start edge
- w  out  1  idle/ready, high only in WAIT
- readnum  out  3  regfile read select
- writenum  out  3  regfile write select
- write  out  1  regfile write enable
- loada  out  1  A operand register load
- loadb  out  1  B operand register load
- loadc  out  1  C result register load
- loads  out  1  status register load
- asel  out  1  1 = ALU A input forced to zero
- bsel  out  1  always 0 in this revision
- vsel  out  2  writeback select: 00 = C, 01 = sximm8, 10/11 unused
- shift  out  2  shifter op, from IR[4:3]
- aluop  out  2  ALU op, from IR[12:11]
- sximm8  out  DATA_W  IR[7:0] sign-extended
- illegal  out  1  one-cycle pulse on an unsupported opcode

Behaviour:
- Instruction register (IR) loads instr on the rising edge where state=WAIT and s=1. instr is don't-care at all other times.
- Fields: opcode = IR[15:13], op = IR[12:11], Rn = IR[10:8], Rd = IR[7:5], sh = IR[4:3], Rm = IR[2:0].
- States: WAIT, DECODE, GET_A, GET_B, EXEC, WRITE_REG, WRITE_IMM.
- Transitions:
  - WAIT -> DECODE on s=1.
  - DECODE:
    - 110/10 (MOV imm) -> WRITE_IMM
    - 110/00 (MOV reg) -> GET_B
    - 101/00 ADD, 101/01 CMP, 101/10 AND -> GET_A
    - 101/11 MVN -> GET_B
    - any other opcode/op -> WAIT, with illegal=1 during DECODE
  - GET_A -> GET_B.
  - GET_B -> EXEC.
  - EXEC -> WAIT for CMP; otherwise -> WRITE_REG.
  - WRITE_REG -> WAIT. WRITE_IMM -> WAIT.
- Outputs per state (all unlisted enables are 0):
  - GET_A: readnum=Rn, loada=1.
  - GET_B: readnum=Rm, loadb=1.
  - EXEC: loadc=1; asel=1 for MOV reg and MVN; loads=1 only for CMP.
  - WRITE_REG: writenum=Rd, vsel=00, write=1.
  - WRITE_IMM: writenum=Rn, vsel=01, write=1.
- shift, aluop and sximm8 are driven from IR continuously. shift is forced to 00 for MOV imm.
- readnum/writenum hold 000 outside their states.
- Latency, in edges from the accepted start to w=1: MOV imm 3; MOV reg and MVN 5; ADD and AND 6; CMP 5; illegal 2.
- Exactly one write pulse per writing instruction. CMP and illegal never assert write.
- s held high continuously: a new instruction is accepted on the edge where the FSM re-enters WAIT's successor. A back-to-back start is accepted on the first cycle w=1.
- Reset (any state, any time): state=WAIT, IR=0, w=1, all other outputs 0. An instruction aborted mid-flight performs no write.

Optional Feature:
- Macro: SMC_RETIRE_CNT_EN.
- Defined:
  - Adds output retired[15:0], reset to 0.
  - Increments on each edge leaving WRITE_REG or WRITE_IMM, and on EXEC->WAIT for CMP.
  - Wraps 0xFFFF -> 0x0000. Illegal instructions do not count.
- Undefined: port and counter are absent. All other behaviour is identical.

Test Plan:
- Reset with reset_n low mid-EXEC of ADD 0xA140 -> immediately w=1, write=0, no write pulse after release.
- s=1, instr=0xD007 (MOV R0,#7) -> write=1 with writenum=0, vsel=01, sximm8=0x0007 on cycle 2; w=1 at edge 3.
- instr=0xD1FE (MOV R1,#-2) -> sximm8=0xFFFE, writenum=1.
- instr=0xA140 (ADD R2,R1,R0) -> GET_A readnum=1, loada; GET_B readnum=0, loadb; EXEC loadc, asel=0, aluop=00; WRITE_REG writenum=2; w at edge 6.
- instr=0xA801 (CMP R0,R1) -> EXEC loads=1, aluop=01, no write, w at edge 5.
- instr=0x0000 -> illegal=1 for exactly one cycle, w at edge 2, no enables. With SMC_RETIRE_CNT_EN, retired unchanged.
